// File: rtl/axis_ingress_fifo_if.sv
// AXI4-Stream bundle for the ingress FIFO. A beat transfers on a rising clk edge
// when tvalid && tready; the master holds tvalid and its payload stable until then.
interface axis_ingress_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_ingress_fifo.sv
// Elastic AXI-stream ingress FIFO (first-word-fall-through, cut-through or store-and-forward).
// Optional rx statistics counters are enabled by defining AXIS_INGRESS_STATS_EN.
module axis_ingress_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 16,
  parameter int STORE_FWD  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axis_ingress_fifo_if.slave     s,
  axis_ingress_fifo_if.master    m,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] frames
`ifdef AXIS_INGRESS_STATS_EN
  ,
  output logic [31:0]            rx_frames,
  output logic [31:0]            rx_stall
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = USER_WIDTH + 1 + DATA_WIDTH;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic [LW-1:0] frames_q;
  logic [LW-1:0] frames_d;
  logic [EW-1:0] hold_q;
  logic [EW-1:0] out_word;
  logic          ready_en_q;
  logic          wr;
  logic          rd;
  logic          wr_last;
  logic          rd_last;
  logic          nonempty;
  logic          full;
  logic          out_valid;

  assign nonempty = (level_q != '0);
  assign full     = (level_q == FULL_LVL);

  // ready_en_q keeps s_tready low until the first edge after reset release.
  assign s.tready = ready_en_q && !full;
  assign wr       = s.tvalid && s.tready;
  assign rd       = out_valid && m.tready;

  // When empty, present the last word read so m_* hold their value.
  assign out_word = nonempty ? mem_q[rd_ptr_q] : hold_q;
  assign m.tvalid = out_valid;
  assign m.tdata  = out_word[DATA_WIDTH-1:0];
  assign m.tlast  = out_word[DATA_WIDTH];
  assign m.tuser  = out_word[EW-1 -: USER_WIDTH];

  assign wr_last = wr && s.tlast;
  assign rd_last = rd && out_word[DATA_WIDTH];

  assign level  = level_q;
  assign frames = frames_q;

  always_comb begin
    level_d  = level_q;
    frames_d = frames_q;
    if (wr && !rd)      level_d = level_q + 1'b1;
    else if (rd && !wr) level_d = level_q - 1'b1;
    if (wr_last && !rd_last)      frames_d = frames_q + 1'b1;
    else if (rd_last && !wr_last) frames_d = frames_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      frames_q   <= '0;
      hold_q     <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      level_q    <= level_d;
      frames_q   <= frames_d;
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        hold_q   <= out_word;
      end
    end
  end

  // Storage is only observed once written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= {s.tuser, s.tlast, s.tdata};
  end

  if (STORE_FWD != 0) begin : g_store_fwd
    logic draining_q;
    logic draining_d;

    // Once an oversize frame starts leaving via the full-escape, keep it flowing to tlast.
    always_comb begin
      draining_d = draining_q;
      if (rd_last)                      draining_d = 1'b0;
      else if (rd && frames_q == '0)    draining_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) draining_q <= 1'b0;
      else        draining_q <= draining_d;
    end

    assign out_valid = nonempty && ((frames_q != '0) || full || draining_q);
  end else begin : g_cut_through
    assign out_valid = nonempty;
  end

`ifdef AXIS_INGRESS_STATS_EN
  logic [31:0] rx_frames_q;
  logic [31:0] rx_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_frames_q <= '0;
      rx_stall_q  <= '0;
    end else begin
      if (wr_last) rx_frames_q <= rx_frames_q + 32'd1;
      if (s.tvalid && !s.tready && (rx_stall_q != 32'hFFFF_FFFF))
        rx_stall_q <= rx_stall_q + 32'd1;
    end
  end

  assign rx_frames = rx_frames_q;
  assign rx_stall  = rx_stall_q;
`endif
endmodule

// File: tb/tb_axis_ingress_fifo.sv
// Directed bench for axis_ingress_fifo: cut-through DEPTH=4, store-and-forward DEPTH=8 and DEPTH=4.
module tb_axis_ingress_fifo;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  axis_ingress_fifo_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) s4 ();
  axis_ingress_fifo_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) m4 ();
  axis_ingress_fifo_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) s8sf ();
  axis_ingress_fifo_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) m8sf ();
  axis_ingress_fifo_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) s4sf ();
  axis_ingress_fifo_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) m4sf ();

  logic [2:0] lvl4, frm4, lvl4sf, frm4sf;
  logic [3:0] lvl8sf, frm8sf;
`ifdef AXIS_INGRESS_STATS_EN
  logic [31:0] rxf4, rxs4, rxf8sf, rxs8sf, rxf4sf, rxs4sf;
`endif

  axis_ingress_fifo #(.DATA_WIDTH(8), .USER_WIDTH(1), .DEPTH(4), .STORE_FWD(0)) u4 (
    .clk(clk), .rst_n(rst_n), .s(s4), .m(m4), .level(lvl4), .frames(frm4)
`ifdef AXIS_INGRESS_STATS_EN
    , .rx_frames(rxf4), .rx_stall(rxs4)
`endif
  );

  axis_ingress_fifo #(.DATA_WIDTH(8), .USER_WIDTH(1), .DEPTH(8), .STORE_FWD(1)) u8sf (
    .clk(clk), .rst_n(rst_n), .s(s8sf), .m(m8sf), .level(lvl8sf), .frames(frm8sf)
`ifdef AXIS_INGRESS_STATS_EN
    , .rx_frames(rxf8sf), .rx_stall(rxs8sf)
`endif
  );

  axis_ingress_fifo #(.DATA_WIDTH(8), .USER_WIDTH(1), .DEPTH(4), .STORE_FWD(1)) u4sf (
    .clk(clk), .rst_n(rst_n), .s(s4sf), .m(m4sf), .level(lvl4sf), .frames(frm4sf)
`ifdef AXIS_INGRESS_STATS_EN
    , .rx_frames(rxf4sf), .rx_stall(rxs4sf)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_checks++; if (s4.tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_tready: got %0b want 0", s4.tready); end
    n_checks++; if (m4.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %0b want 0", m4.tvalid); end
    n_checks++; if (m4.tdata !== 8'h00) begin n_fail++; $display("FAIL reset_m_tdata: got %h want 00", m4.tdata); end
    n_checks++; if (lvl4 !== 3'd0 || frm4 !== 3'd0) begin n_fail++; $display("FAIL reset_counts: level %0d frames %0d want 0 0", lvl4, frm4); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (s4.tready !== 1'b1) begin n_fail++; $display("FAIL release_s_tready_u4: got %0b want 1", s4.tready); end
    n_checks++; if (s8sf.tready !== 1'b1) begin n_fail++; $display("FAIL release_s_tready_u8sf: got %0b want 1", s8sf.tready); end
    n_checks++; if (s4sf.tready !== 1'b1) begin n_fail++; $display("FAIL release_s_tready_u4sf: got %0b want 1", s4sf.tready); end
  endtask

  // 3-beat frame, sink always ready: one cycle latency, level stays at most 1.
  task automatic test_cut_through;
    logic [7:0] dat [3] = '{8'h11, 8'h22, 8'h33};
    int exp_lvl [5] = '{0, 1, 1, 1, 0};
    int exp_frm [5] = '{0, 0, 0, 1, 0};
    m4.tready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      s4.tvalid = (c < 3);
      s4.tdata  = (c < 3) ? dat[c] : 8'h00;
      s4.tlast  = (c == 2);
      s4.tuser  = 1'b0;
      @(negedge clk);
      n_checks++; if (lvl4 !== 3'(exp_lvl[c])) begin n_fail++; $display("FAIL ct_level c%0d: got %0d want %0d", c, lvl4, exp_lvl[c]); end
      n_checks++; if (frm4 !== 3'(exp_frm[c])) begin n_fail++; $display("FAIL ct_frames c%0d: got %0d want %0d", c, frm4, exp_frm[c]); end
      if (c >= 1 && c <= 3) begin
        n_checks++; if (m4.tvalid !== 1'b1 || m4.tdata !== dat[c-1]) begin n_fail++; $display("FAIL ct_data c%0d: valid %0b data %h want 1 %h", c, m4.tvalid, m4.tdata, dat[c-1]); end
        n_checks++; if (m4.tlast !== (c == 3)) begin n_fail++; $display("FAIL ct_tlast c%0d: got %0b want %0b", c, m4.tlast, (c == 3)); end
      end else begin
        n_checks++; if (m4.tvalid !== 1'b0) begin n_fail++; $display("FAIL ct_idle_valid c%0d: got %0b want 0", c, m4.tvalid); end
      end
    end
    n_checks++; if (m4.tdata !== 8'h33) begin n_fail++; $display("FAIL ct_hold_data: got %h want 33", m4.tdata); end
  endtask

  // Sink stalled: 4 of the offered beats fit, then one read frees one slot.
  task automatic test_full_backpressure;
    m4.tready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      s4.tvalid = 1'b1;
      s4.tdata  = (c < 4) ? 8'(c) : 8'd4;
      s4.tlast  = 1'b0;
      @(negedge clk);
      if (c < 4) begin
        n_checks++; if (s4.tready !== 1'b1 || lvl4 !== 3'(c)) begin n_fail++; $display("FAIL bp_fill c%0d: ready %0b level %0d want 1 %0d", c, s4.tready, lvl4, c); end
      end else begin
        n_checks++; if (s4.tready !== 1'b0 || lvl4 !== 3'd4) begin n_fail++; $display("FAIL bp_full c%0d: ready %0b level %0d want 0 4", c, s4.tready, lvl4); end
      end
    end
    @(posedge clk); #1;
    m4.tready = 1'b1;
    @(negedge clk);
    n_checks++; if (m4.tvalid !== 1'b1 || m4.tdata !== 8'd0 || s4.tready !== 1'b0) begin n_fail++; $display("FAIL bp_head: valid %0b data %h ready %0b want 1 00 0", m4.tvalid, m4.tdata, s4.tready); end
    @(posedge clk); #1;
    m4.tready = 1'b0;
    @(negedge clk);
    n_checks++; if (s4.tready !== 1'b1 || lvl4 !== 3'd3 || m4.tdata !== 8'd1) begin n_fail++; $display("FAIL bp_freed: ready %0b level %0d data %h want 1 3 01", s4.tready, lvl4, m4.tdata); end
    @(posedge clk); #1;
    s4.tvalid = 1'b0;
    m4.tready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++; if (m4.tvalid !== 1'b1 || m4.tdata !== 8'(k)) begin n_fail++; $display("FAIL bp_order k%0d: valid %0b data %h want 1 %h", k, m4.tvalid, m4.tdata, 8'(k)); end
    end
    @(negedge clk);
    n_checks++; if (lvl4 !== 3'd0 || m4.tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: level %0d valid %0b want 0 0", lvl4, m4.tvalid); end
  endtask

  // Store-and-forward: nothing leaves until the tlast beat is stored.
  task automatic test_store_forward;
    logic       drv_v [9] = '{1, 1, 0, 0, 1, 0, 0, 0, 0};
    logic [7:0] drv_d [9] = '{8'hA1, 8'hA2, 0, 0, 8'hA3, 0, 0, 0, 0};
    logic       exp_v [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
    logic [7:0] exp_d [9] = '{0, 0, 0, 0, 0, 8'hA1, 8'hA2, 8'hA3, 0};
    int exp_lvl [9] = '{0, 1, 2, 2, 2, 3, 2, 1, 0};
    int exp_frm [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
    m8sf.tready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      s8sf.tvalid = drv_v[c];
      s8sf.tdata  = drv_d[c];
      s8sf.tlast  = (c == 4);
      s8sf.tuser  = 1'b0;
      @(negedge clk);
      n_checks++; if (m8sf.tvalid !== exp_v[c]) begin n_fail++; $display("FAIL sf_valid c%0d: got %0b want %0b", c, m8sf.tvalid, exp_v[c]); end
      n_checks++; if (lvl8sf !== 4'(exp_lvl[c]) || frm8sf !== 4'(exp_frm[c])) begin n_fail++; $display("FAIL sf_counts c%0d: level %0d frames %0d want %0d %0d", c, lvl8sf, frm8sf, exp_lvl[c], exp_frm[c]); end
      if (exp_v[c]) begin
        n_checks++; if (m8sf.tdata !== exp_d[c]) begin n_fail++; $display("FAIL sf_data c%0d: got %h want %h", c, m8sf.tdata, exp_d[c]); end
      end
    end
  endtask

  // 10-beat frame into a 4-deep store-and-forward FIFO must escape via the full condition.
  task automatic test_oversize_escape;
    logic [7:0] exp_q [$];
    int   sent;
    int   rcvd;
    int   lasts;
    logic seen_escape;
    logic [2:0] max_lvl;
    sent = 0; rcvd = 0; lasts = 0; seen_escape = 1'b0; max_lvl = '0;
    m4sf.tready = 1'b1;
    for (int cyc = 0; cyc < 100 && rcvd < 10; cyc++) begin
      @(posedge clk); #1;
      s4sf.tvalid = (sent < 10);
      s4sf.tdata  = 8'h80 + 8'(sent);
      s4sf.tlast  = (sent == 9);
      s4sf.tuser  = 1'b0;
      @(negedge clk);
      if (lvl4sf > max_lvl) max_lvl = lvl4sf;
      if (m4sf.tvalid && frm4sf == 3'd0) seen_escape = 1'b1;
      if (m4sf.tvalid && m4sf.tready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL os_data beat%0d: got %h with nothing expected", rcvd, m4sf.tdata); end
        else if (m4sf.tdata !== exp_q[0]) begin n_fail++; $display("FAIL os_data beat%0d: got %h want %h", rcvd, m4sf.tdata, exp_q[0]); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        n_checks++; if (m4sf.tlast !== (rcvd == 9)) begin n_fail++; $display("FAIL os_tlast beat%0d: got %0b want %0b", rcvd, m4sf.tlast, (rcvd == 9)); end
        if (m4sf.tlast) lasts++;
        rcvd++;
      end
      if (s4sf.tvalid && s4sf.tready) begin
        exp_q.push_back(s4sf.tdata);
        sent++;
      end
    end
    s4sf.tvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (rcvd != 10) begin n_fail++; $display("FAIL os_timeout: received %0d want 10", rcvd); end
    n_checks++; if (max_lvl !== 3'd4) begin n_fail++; $display("FAIL os_max_level: got %0d want 4", max_lvl); end
    n_checks++; if (seen_escape !== 1'b1) begin n_fail++; $display("FAIL os_escape: got %0b want 1", seen_escape); end
    n_checks++; if (lasts != 1) begin n_fail++; $display("FAIL os_tlast_count: got %0d want 1", lasts); end
    n_checks++; if (lvl4sf !== 3'd0 || frm4sf !== 3'd0 || m4sf.tvalid !== 1'b0) begin n_fail++; $display("FAIL os_end: level %0d frames %0d valid %0b want 0 0 0", lvl4sf, frm4sf, m4sf.tvalid); end
  endtask

  // Simultaneous write/read at level 2 carrying tuser, then a mid-frame reset.
  task automatic test_back_to_back;
    m4.tready = 1'b0;
    s4.tuser  = 1'b0;
    @(posedge clk); #1; s4.tvalid = 1'b1; s4.tdata = 8'h50; s4.tlast = 1'b0;
    @(posedge clk); #1; s4.tdata = 8'h51;
    @(posedge clk); #1; s4.tdata = 8'h52; s4.tuser = 1'b1; s4.tlast = 1'b1; m4.tready = 1'b1;
    @(negedge clk);
    n_checks++; if (lvl4 !== 3'd2 || m4.tdata !== 8'h50) begin n_fail++; $display("FAIL b2b_pre: level %0d data %h want 2 50", lvl4, m4.tdata); end
    @(posedge clk); #1; s4.tvalid = 1'b0; s4.tuser = 1'b0; s4.tlast = 1'b0;
    @(negedge clk);
    n_checks++; if (lvl4 !== 3'd2 || m4.tdata !== 8'h51 || m4.tuser !== 1'b0) begin n_fail++; $display("FAIL b2b_same_level: level %0d data %h user %0b want 2 51 0", lvl4, m4.tdata, m4.tuser); end
    @(negedge clk);
    n_checks++; if (m4.tdata !== 8'h52 || m4.tuser !== 1'b1 || m4.tlast !== 1'b1 || frm4 !== 3'd1) begin n_fail++; $display("FAIL b2b_tuser: data %h user %0b last %0b frames %0d want 52 1 1 1", m4.tdata, m4.tuser, m4.tlast, frm4); end
    @(negedge clk);
    n_checks++; if (lvl4 !== 3'd0 || frm4 !== 3'd0) begin n_fail++; $display("FAIL b2b_drained: level %0d frames %0d want 0 0", lvl4, frm4); end
    @(posedge clk); #1; m4.tready = 1'b0; s4.tvalid = 1'b1; s4.tdata = 8'h60; s4.tlast = 1'b1;
    @(posedge clk); #1; s4.tdata = 8'h61; s4.tlast = 1'b0;
    @(posedge clk); #1; s4.tvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (lvl4 !== 3'd2 || frm4 !== 3'd1 || m4.tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: level %0d frames %0d valid %0b want 2 1 1", lvl4, frm4, m4.tvalid); end
    #2; rst_n = 1'b0; #1;
    n_checks++; if (m4.tvalid !== 1'b0 || lvl4 !== 3'd0 || frm4 !== 3'd0) begin n_fail++; $display("FAIL mid_reset: valid %0b level %0d frames %0d want 0 0 0", m4.tvalid, lvl4, frm4); end
    n_checks++; if (s4.tready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got %0b want 0", s4.tready); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (s4.tready !== 1'b1 || m4.tdata !== 8'h00 || lvl4 !== 3'd0) begin n_fail++; $display("FAIL mid_release: ready %0b data %h level %0d want 1 00 0", s4.tready, m4.tdata, lvl4); end
  endtask

`ifdef AXIS_INGRESS_STATS_EN
  // 5 single-beat frames, then fill to full and hold s_tvalid for 7 stalled cycles.
  task automatic test_stats;
    m4.tready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      @(posedge clk); #1; s4.tvalid = 1'b1; s4.tdata = 8'hC0 + 8'(f); s4.tlast = 1'b1;
    end
    @(posedge clk); #1; s4.tvalid = 1'b0; s4.tlast = 1'b0;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1; m4.tready = 1'b0; s4.tvalid = 1'b1; s4.tdata = 8'(c);
    end
    @(posedge clk); #1; s4.tvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (rxf4 !== 32'd5) begin n_fail++; $display("FAIL stats_frames: got %0d want 5", rxf4); end
    n_checks++; if (rxs4 !== 32'd7) begin n_fail++; $display("FAIL stats_stall: got %0d want 7", rxs4); end
    #2; rst_n = 1'b0; #1;
    n_checks++; if (rxf4 !== 32'd0 || rxs4 !== 32'd0) begin n_fail++; $display("FAIL stats_reset: frames %0d stall %0d want 0 0", rxf4, rxs4); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    s4.tvalid = 1'b0;   s4.tdata = '0;   s4.tlast = 1'b0;   s4.tuser = '0;   m4.tready = 1'b0;
    s8sf.tvalid = 1'b0; s8sf.tdata = '0; s8sf.tlast = 1'b0; s8sf.tuser = '0; m8sf.tready = 1'b0;
    s4sf.tvalid = 1'b0; s4sf.tdata = '0; s4sf.tlast = 1'b0; s4sf.tuser = '0; m4sf.tready = 1'b0;

    test_reset();
    test_cut_through();
    test_full_backpressure();
    test_store_forward();
    test_oversize_escape();
    test_back_to_back();
`ifdef AXIS_INGRESS_STATS_EN
    test_stats();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
